// File: rtl/regfile_mp.sv
// Multi-write, multi-read register file with 1-cycle registered reads and a post-reset clear sequencer.
// Latency: reads 1 cycle (captured at posedge N, visible N+1); writes commit at the posedge; init_done_o after els_p posedges.
// No backpressure: traffic is ignored until init_done_o; optional parity via macro REGFILE_MP_PARITY_EN.
module regfile_mp #(
  parameter int width_p           = 32,
  parameter int els_p             = 32,
  parameter int num_rs_p          = 2,
  parameter int num_ws_p          = 2,
  parameter int x0_tied_to_zero_p = 1,
  parameter int bypass_p          = 1,
  localparam int addr_width_lp    = (els_p == 1) ? 1 : $clog2(els_p)
) (
  input  logic                                    clk_i,
  input  logic                                    reset_i,
  output logic                                    init_done_o,
  input  logic [num_ws_p-1:0]                     w_v_i,
  input  logic [num_ws_p-1:0][addr_width_lp-1:0]  w_addr_i,
  input  logic [num_ws_p-1:0][width_p-1:0]        w_data_i,
  input  logic [num_rs_p-1:0]                     r_v_i,
  input  logic [num_rs_p-1:0][addr_width_lp-1:0]  r_addr_i,
`ifdef REGFILE_MP_PARITY_EN
  output logic [num_rs_p-1:0]                     r_parity_err_o,
`endif
  output logic [num_rs_p-1:0][width_p-1:0]        r_data_o
);

  typedef enum logic {CLEAR_S, READY_S} state_e;

  state_e                                 state_q;
  logic [addr_width_lp-1:0]               cnt_q;
  logic                                   init_done_q;

  logic [width_p-1:0]                     mem_q [els_p];
  logic [width_p-1:0]                     mem_d [els_p];
  logic [els_p-1:0]                       mem_we;

  logic [num_ws_p-1:0]                    w_ok;
  logic [num_rs_p-1:0]                    byp_hit;
  logic [num_rs_p-1:0][width_p-1:0]       byp_dat;

  logic [num_rs_p-1:0][width_p-1:0]       r_data_q;
  logic [num_rs_p-1:0][width_p-1:0]       r_data_d;

  // Entry exists (non-power-of-two depth leaves holes at the top of the address space).
  function automatic logic addr_in_range(input logic [addr_width_lp-1:0] a);
    return (32'(a) < 32'(els_p));
  endfunction

  // Entry 0 is hard-wired to zero when x0 tying is enabled.
  function automatic logic addr_is_x0(input logic [addr_width_lp-1:0] a);
    return (x0_tied_to_zero_p != 0) && (a == '0);
  endfunction

  // Clear sequencer: walks every entry once after reset, then parks in READY.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= CLEAR_S;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        CLEAR_S: begin
          if (cnt_q == addr_width_lp'(els_p - 1)) begin
            state_q     <= READY_S;
            init_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + addr_width_lp'(1);
          end
        end
        default: begin
          state_q     <= READY_S;
          init_done_q <= 1'b1;
        end
      endcase
    end
  end

  assign init_done_o = init_done_q;

  // Qualify each write port: ready, valid, real entry, not the tied-zero entry.
  always_comb begin
    w_ok = '0;
    for (int p = 0; p < num_ws_p; p++) begin
      w_ok[p] = (state_q == READY_S) && w_v_i[p]
              && addr_in_range(w_addr_i[p]) && !addr_is_x0(w_addr_i[p]);
    end
  end

  // Per-entry write decode; ascending port loop lets the highest-indexed port win a collision.
  always_comb begin
    mem_we = '0;
    for (int e = 0; e < els_p; e++) begin
      mem_d[e] = '0;
    end
    if (state_q == CLEAR_S) begin
      mem_we[cnt_q] = 1'b1;
      mem_d[cnt_q]  = '0;
    end else begin
      for (int p = 0; p < num_ws_p; p++) begin
        if (w_ok[p]) begin
          mem_we[w_addr_i[p]] = 1'b1;
          mem_d[w_addr_i[p]]  = w_data_i[p];
        end
      end
    end
  end

  // Storage array; contents are deliberately not reset, the sequencer zeroes them.
  always_ff @(posedge clk_i) begin
    for (int e = 0; e < els_p; e++) begin
      if (mem_we[e]) begin
        mem_q[e] <= mem_d[e];
      end
    end
  end

  // Forwarding match per read port, again with highest write port winning.
  always_comb begin
    byp_hit = '0;
    byp_dat = '0;
    for (int k = 0; k < num_rs_p; k++) begin
      for (int p = 0; p < num_ws_p; p++) begin
        if (w_ok[p] && (w_addr_i[p] == r_addr_i[k])) begin
          byp_hit[k] = 1'b1;
          byp_dat[k] = w_data_i[p];
        end
      end
    end
  end

  // Read data next-state: hold when idle, zero during clear, forward or read the array otherwise.
  always_comb begin
    r_data_d = r_data_q;
    for (int k = 0; k < num_rs_p; k++) begin
      if (state_q == CLEAR_S) begin
        r_data_d[k] = '0;
      end else if (r_v_i[k]) begin
        if (addr_is_x0(r_addr_i[k]) || !addr_in_range(r_addr_i[k])) begin
          r_data_d[k] = '0;
        end else if ((bypass_p != 0) && byp_hit[k]) begin
          r_data_d[k] = byp_dat[k];
        end else begin
          r_data_d[k] = mem_q[r_addr_i[k]];
        end
      end
    end
  end

  // Registered read data, cleared asynchronously by reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_data_q <= '0;
    end else begin
      r_data_q <= r_data_d;
    end
  end

  assign r_data_o = r_data_q;

`ifdef REGFILE_MP_PARITY_EN
  logic [els_p-1:0]    par_q;
  logic [num_rs_p-1:0] r_perr_q;
  logic [num_rs_p-1:0] r_perr_d;

  // Even parity stored beside each entry; the clear sequencer writes data 0 so parity 0.
  always_ff @(posedge clk_i) begin
    for (int e = 0; e < els_p; e++) begin
      if (mem_we[e]) begin
        par_q[e] <= ^mem_d[e];
      end
    end
  end

  // Parity error follows the data path; forwarded and zero-returning reads never flag.
  always_comb begin
    r_perr_d = r_perr_q;
    for (int k = 0; k < num_rs_p; k++) begin
      if (state_q == CLEAR_S) begin
        r_perr_d[k] = 1'b0;
      end else if (r_v_i[k]) begin
        if (addr_is_x0(r_addr_i[k]) || !addr_in_range(r_addr_i[k])) begin
          r_perr_d[k] = 1'b0;
        end else if ((bypass_p != 0) && byp_hit[k]) begin
          r_perr_d[k] = 1'b0;
        end else begin
          r_perr_d[k] = par_q[r_addr_i[k]] ^ (^mem_q[r_addr_i[k]]);
        end
      end
    end
  end

  // Registered parity error flag, aligned with r_data_o.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_perr_q <= '0;
    end else begin
      r_perr_q <= r_perr_d;
    end
  end

  assign r_parity_err_o = r_perr_q;
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed steps plus random traffic against an array-based reference model.
// Model checks init_done_o and both read ports after every clock.
// Inputs change 1 time unit after the rising edge; outputs are sampled there as well.
module tb_regfile_mp;
  localparam int W      = 32;
  localparam int N      = 32;
  localparam int BYPASS = 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             init_done;
  logic [1:0]       w_v;
  logic [1:0][4:0]  w_addr;
  logic [1:0][W-1:0] w_data;
  logic [1:0]       r_v;
  logic [1:0][4:0]  r_addr;
  logic [1:0][W-1:0] r_data;
`ifdef REGFILE_MP_PARITY_EN
  logic [1:0]       r_perr;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model
  logic [W-1:0] m_mem [N];
  logic [W-1:0] m_r   [2];
  int           clr_cnt = 0;
  bit           m_rst   = 1'b0;

  regfile_mp #(
    .width_p(W), .els_p(N), .num_rs_p(2), .num_ws_p(2),
    .x0_tied_to_zero_p(1), .bypass_p(BYPASS)
  ) dut (
    .clk_i(clk),
    .reset_i(rst),
    .init_done_o(init_done),
    .w_v_i(w_v),
    .w_addr_i(w_addr),
    .w_data_i(w_data),
    .r_v_i(r_v),
    .r_addr_i(r_addr),
`ifdef REGFILE_MP_PARITY_EN
    .r_parity_err_o(r_perr),
`endif
    .r_data_o(r_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    w_v = '0; w_addr = '0; w_data = '0;
    r_v = '0; r_addr = '0;
  endtask

  // One clock: predict from the rules, advance, compare.
  task automatic tick();
    logic [W-1:0] nm [N];
    logic [W-1:0] nr [2];
    logic [W-1:0] val;
    nm = m_mem;
    nr = m_r;
    if (!m_rst && clr_cnt >= N) begin
      for (int k = 0; k < 2; k++) begin
        if (r_v[k]) begin
          if (r_addr[k] == 0) begin
            nr[k] = '0;
          end else begin
            val = m_mem[r_addr[k]];
            if (BYPASS != 0) begin
              for (int p = 0; p < 2; p++)
                if (w_v[p] && w_addr[p] == r_addr[k]) val = w_data[p];
            end
            nr[k] = val;
          end
        end
      end
      for (int p = 0; p < 2; p++)
        if (w_v[p] && w_addr[p] != 0) nm[w_addr[p]] = w_data[p];
    end else if (!m_rst) begin
      clr_cnt++;
    end
    @(posedge clk);
    #1;
    m_mem = nm;
    m_r   = nr;
    chk("init_done", {31'd0, init_done}, {31'd0, (!m_rst && clr_cnt >= N)});
    chk("r_data0", r_data[0], m_r[0]);
    chk("r_data1", r_data[1], m_r[1]);
  endtask

  // Assert reset asynchronously and check the immediate effect.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    m_rst   = 1'b1;
    clr_cnt = 0;
    m_r[0]  = '0;
    m_r[1]  = '0;
    for (int i = 0; i < N; i++) m_mem[i] = '0;
    chk("rst_init_done", {31'd0, init_done}, 32'd0);
    chk("rst_r_data0", r_data[0], 32'd0);
    chk("rst_r_data1", r_data[1], 32'd0);
  endtask

  task automatic release_reset();
    rst   = 1'b0;
    m_rst = 1'b0;
  endtask

  task automatic rand_inputs();
    for (int p = 0; p < 2; p++) begin
      w_v[p]    = 1'($urandom_range(0, 1));
      w_addr[p] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, N - 1));
      w_data[p] = $urandom;
    end
    for (int k = 0; k < 2; k++) begin
      r_v[k]    = 1'($urandom_range(0, 1));
      r_addr[k] = ($urandom_range(0, 2) == 0) ? w_addr[$urandom_range(0, 1)] : 5'($urandom_range(0, N - 1));
    end
  endtask

  initial begin
    idle();
    m_r[0] = '0;
    m_r[1] = '0;
    #2;
    do_reset();
    tick();
    tick();
    release_reset();

    // Clear sequence: init_done_o must rise after exactly N posedges
    for (int i = 0; i < N; i++) tick();
    chk("init_after_clear", {31'd0, init_done}, 32'd1);

    // Every entry reads zero after clear
    for (int i = 0; i < N; i++) begin
      idle(); r_v[0] = 1'b1; r_addr[0] = 5'(i);
      tick();
    end

    // Basic write, read back, then hold while idle
    idle(); w_v[0] = 1'b1; w_addr[0] = 5'd5; w_data[0] = 32'hDEADBEEF;
    tick();
    idle(); r_v[0] = 1'b1; r_addr[0] = 5'd5;
    tick();
    chk("basic_rd", r_data[0], 32'hDEADBEEF);
    idle();
    for (int i = 0; i < 10; i++) tick();
    chk("basic_hold", r_data[0], 32'hDEADBEEF);

    // Same-cycle write and read of one address
    idle(); w_v[0] = 1'b1; w_addr[0] = 5'd7; w_data[0] = 32'h0000AAAA;
    tick();
    idle(); w_v[1] = 1'b1; w_addr[1] = 5'd7; w_data[1] = 32'h00001234;
    r_v[0] = 1'b1; r_addr[0] = 5'd7;
    tick();
    chk("bypass_rd", r_data[0], (BYPASS != 0) ? 32'h00001234 : 32'h0000AAAA);
    idle(); r_v[0] = 1'b1; r_addr[0] = 5'd7;
    tick();
    chk("post_bypass_rd", r_data[0], 32'h00001234);

    // Same-address collision: port 1 wins; different addresses both commit
    idle(); w_v = 2'b11; w_addr[0] = 5'd3; w_data[0] = 32'h11; w_addr[1] = 5'd3; w_data[1] = 32'h22;
    tick();
    idle(); w_v = 2'b11; w_addr[0] = 5'd4; w_data[0] = 32'h33; w_addr[1] = 5'd9; w_data[1] = 32'h44;
    r_v[0] = 1'b1; r_addr[0] = 5'd3;
    tick();
    chk("conflict_rd", r_data[0], 32'h22);
    idle(); r_v = 2'b11; r_addr[0] = 5'd4; r_addr[1] = 5'd9;
    tick();
    chk("dual_wr_a", r_data[0], 32'h33);
    chk("dual_wr_b", r_data[1], 32'h44);

    // Address 0 stays zero even with a same-cycle write
    idle(); w_v = 2'b11; w_data[0] = 32'hFFFFFFFF; w_data[1] = 32'hFFFFFFFF;
    r_v = 2'b11;
    tick();
    chk("x0_rd0", r_data[0], 32'd0);
    chk("x0_rd1", r_data[1], 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      tick();
    end

    // Reset out of READY with read data nonzero, then reset again mid-clear
    idle(); r_v[0] = 1'b1; r_addr[0] = 5'd5;
    tick();
    do_reset();
    idle();
    tick();
    release_reset();
    for (int i = 0; i < 10; i++) begin
      rand_inputs();
      tick();
    end
    chk("midclear_cnt", 32'(clr_cnt), 32'd10);
    do_reset();
    idle();
    tick();
    release_reset();
    for (int i = 0; i < N; i++) begin
      rand_inputs();
      w_v = 2'b11;
      tick();
    end
    for (int i = 0; i < N; i++) begin
      idle(); r_v = 2'b11; r_addr[0] = 5'(i); r_addr[1] = 5'((i + 1) % N);
      tick();
    end
    chk("clear_wipes_writes", r_data[0], 32'd0);

`ifdef REGFILE_MP_PARITY_EN
    idle(); w_v[0] = 1'b1; w_addr[0] = 5'd6; w_data[0] = 32'h000000F0;
    tick();
    dut.mem_q[6][0] = ~dut.mem_q[6][0];
    m_mem[6][0] = ~m_mem[6][0];
    idle(); r_v[0] = 1'b1; r_addr[0] = 5'd6;
    tick();
    chk("parity_err", {31'd0, r_perr[0]}, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
